// File: rtl/event_dispatcher_pkg.sv
// Shared types and constants for the event dispatcher slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: dispatcher FSM state enum, default parameter values and the
// width of the CSR recv/processed counters.

package event_dispatcher_pkg;

  localparam int DEF_NUM_SRC        = 4;
  localparam int DEF_FIFO_DEPTH     = 4;
  localparam int DEF_TYPE_W         = 32;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  // Width of the CSR unit's recv/processed counters and of the ack-timeout counter.
  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POST = 2'd1,
    WAIT = 2'd2
  } disp_state_e;

endpackage

// File: rtl/event_fifo.sv
// Synchronous single-clock FIFO holding pending event types.
// Latency: a push is visible at head_dat/count on the next cycle.
// Backpressure: push ignored when full, pop ignored when empty; push and pop may coincide.
//
// Ports:
//   clock, reset        single clock, synchronous active-high reset
//   push, push_dat      write strobe and data
//   pop                 remove the head entry
//   head_dat            current head entry (valid while !empty)
//   full, empty, count  occupancy status

module event_fifo
  import event_dispatcher_pkg::*;
#(
  parameter  int WIDTH = DEF_TYPE_W,
  parameter  int DEPTH = DEF_FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/event_dispatcher.sv
// Round-robin intake of source events into a FIFO, posted one at a time to the CSR event interface.
// Latency: grant in N, head in N+1, io_has_event_wr in N+2 when the CSR unit is idle.
// Backpressure: io_src_ready all-zero while the FIFO is full; posts wait until the core has drained the previous event.
//
// Ports:
//   clock, reset                       single clock, synchronous active-high reset
//   io_src_valid/ready/type            per-source request handshake and event type
//   io_has_event_rd                    CSR: event pending, not yet taken by the core
//   io_event_recv_cnt/processed_cnt    CSR event counters
//   io_has_event_wr, io_event_type_wr  one-cycle post strobe and type (type holds last posted value)
//   io_fifo_count                      pending-event occupancy
//   io_timeout                         sticky ack-timeout flag
// Build option: EVENT_DISPATCHER_TIMEOUT_EN adds a WAIT-state ack timeout of TIMEOUT_CYCLES.

module event_dispatcher
  import event_dispatcher_pkg::*;
#(
  parameter  int NUM_SRC        = DEF_NUM_SRC,
  parameter  int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter  int TYPE_W         = DEF_TYPE_W,
  parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int CW             = $clog2(FIFO_DEPTH) + 1,
  localparam int SW             = $clog2(NUM_SRC)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        io_src_valid,
  output logic [NUM_SRC-1:0]        io_src_ready,
  input  logic [NUM_SRC*TYPE_W-1:0] io_src_type,
  input  logic                      io_has_event_rd,
  input  logic [CNT_W-1:0]          io_event_recv_cnt,
  input  logic [CNT_W-1:0]          io_event_processed_cnt,
  output logic                      io_has_event_wr,
  output logic [TYPE_W-1:0]         io_event_type_wr,
  output logic [CW-1:0]             io_fifo_count,
  output logic                      io_timeout
);

  if (NUM_SRC < 2 || NUM_SRC > 8 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("event_dispatcher: parameter out of range");
  end

  disp_state_e       state_q, state_d;
  logic [SW-1:0]     rr_ptr;
  logic [SW:0]       probe;
  logic              gnt_any;
  logic [SW-1:0]     gnt_idx;
  logic              push;
  logic [TYPE_W-1:0] push_dat;
  logic              pop;
  logic [TYPE_W-1:0] head_dat;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  recv_snap;
  logic [TYPE_W-1:0] type_hold;
  logic              acked;
  logic              tmo_hit;

  // Round-robin search starting at rr_ptr; first valid source wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    probe   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      probe = {1'b0, rr_ptr} + (SW+1)'(k);
      if (probe >= (SW+1)'(NUM_SRC)) probe = probe - (SW+1)'(NUM_SRC);
      if (!gnt_any && io_src_valid[probe[SW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = probe[SW-1:0];
      end
    end
  end

  assign push = !reset && gnt_any && !fifo_full;

  always_comb begin
    io_src_ready = '0;
    if (push) io_src_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    push_dat = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (gnt_idx == SW'(k)) push_dat = io_src_type[k*TYPE_W +: TYPE_W];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (push) begin
      rr_ptr <= (gnt_idx == SW'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  event_fifo #(
    .WIDTH (TYPE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (io_fifo_count)
  );

  // The CSR unit signals acceptance by moving its recv counter off the snapshot.
  assign acked = (io_event_recv_cnt != recv_snap);

`ifdef EVENT_DISPATCHER_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_q;

  assign tmo_hit    = (state_q == WAIT) && !acked && (wait_cnt == TMO_LAST);
  assign io_timeout = timeout_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wait_cnt <= (state_q == WAIT && state_d == WAIT) ? wait_cnt + 1'b1 : '0;
      if (tmo_hit) timeout_q <= 1'b1;
    end
  end
`else
  assign tmo_hit    = 1'b0;
  assign io_timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (!fifo_empty && !io_has_event_rd &&
                io_event_recv_cnt == io_event_processed_cnt) state_d = POST;
      POST: state_d = WAIT;
      WAIT: if (acked || tmo_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop              = (state_q == POST);
    io_has_event_wr  = (state_q == POST);
    io_event_type_wr = (state_q == POST) ? head_dat : type_hold;
  end

  // Snapshot recv at post time; keep the posted type visible between posts.
  always_ff @(posedge clock) begin
    if (reset) begin
      recv_snap <= '0;
      type_hold <= '0;
    end else if (state_q == POST) begin
      recv_snap <= io_event_recv_cnt;
      type_hold <= head_dat;
    end
  end

endmodule

// File: tb/tb_event_dispatcher.sv
module tb_event_dispatcher;

  localparam int NS    = 4;
  localparam int DEPTH = 4;
  localparam int TW    = 32;
  localparam int TMO   = 16;
`ifdef EVENT_DISPATCHER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic [NS-1:0]     io_src_valid;
  logic [NS-1:0]     io_src_ready;
  logic [NS*TW-1:0]  io_src_type;
  logic              io_has_event_rd;
  logic [31:0]       recv, processed;
  logic              io_has_event_wr;
  logic [TW-1:0]     io_event_type_wr;
  logic [2:0]        io_fifo_count;
  logic              io_timeout;

  event_dispatcher #(
    .NUM_SRC(NS), .FIFO_DEPTH(DEPTH), .TYPE_W(TW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .io_src_valid           (io_src_valid),
    .io_src_ready           (io_src_ready),
    .io_src_type            (io_src_type),
    .io_has_event_rd        (io_has_event_rd),
    .io_event_recv_cnt      (recv),
    .io_event_processed_cnt (processed),
    .io_has_event_wr        (io_has_event_wr),
    .io_event_type_wr       (io_event_type_wr),
    .io_fifo_count          (io_fifo_count),
    .io_timeout             (io_timeout)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Source emulation: per-source list of pending event types.
  logic [TW-1:0] src_evt [NS][8];
  int            src_n [NS];
  int            src_h [NS];
  bit            auto_ack, auto_proc;
  logic          strobe_last;
  logic [NS-1:0] gnt_last;

  // Observed DUT activity, checked against literal expectations.
  int            post_cyc[$];
  logic [TW-1:0] post_typ[$];
  int            gnt_cyc[$];
  int            gnt_src[$];
  int            max_cnt;
  int            tmo_rise;

  // Behavioural model: queue of pending types plus the dispatcher's posting rules.
  logic [TW-1:0] m_q[$];
  int            m_ptr;
  bit            m_post, m_out, m_tmo;
  logic [31:0]   m_snap;
  logic [TW-1:0] m_last;
  int            m_wcnt;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic int pick();
    for (int k = 0; k < NS; k++) begin
      if (io_src_valid[(m_ptr + k) % NS]) return (m_ptr + k) % NS;
    end
    return -1;
  endfunction

  function automatic logic [NS-1:0] exp_rdy();
    int s;
    logic [NS-1:0] r;
    r = '0;
    if (reset || m_q.size() >= DEPTH) return r;
    s = pick();
    if (s >= 0) r[s] = 1'b1;
    return r;
  endfunction

  always @(posedge clock) begin : model
    int g;
    int sz;
    if (reset) begin
      m_q.delete();
      m_ptr = 0; m_post = 0; m_out = 0; m_tmo = 0;
      m_snap = '0; m_last = '0; m_wcnt = 0;
    end else begin
      sz = m_q.size();
      g  = (sz < DEPTH) ? pick() : -1;
      if (m_post) begin
        m_last = m_q.pop_front();
        m_snap = recv;
        m_out  = 1; m_wcnt = 0; m_post = 0;
      end else if (m_out) begin
        if (recv != m_snap) m_out = 0;
        else begin
          m_wcnt++;
          if (TMO_EN && m_wcnt == TMO) begin m_out = 0; m_tmo = 1; end
        end
      end else if (sz > 0 && !io_has_event_rd && recv == processed) begin
        m_post = 1;
      end
      if (g >= 0) begin
        m_q.push_back(io_src_type[g*TW +: TW]);
        m_ptr = (g + 1) % NS;
      end
    end
  end

  always @(negedge clock) begin : compare
    strobe_last = io_has_event_wr;
    gnt_last    = io_src_valid & io_src_ready;
    chk("has_event_wr",  io_has_event_wr, m_post);
    chk("event_type_wr", io_event_type_wr, m_post ? m_q[0] : m_last);
    chk("fifo_count",    io_fifo_count, m_q.size());
    chk("src_ready",     io_src_ready, exp_rdy());
    chk("timeout",       io_timeout, m_tmo);
    if (io_has_event_wr) begin post_cyc.push_back(cyc); post_typ.push_back(io_event_type_wr); end
    for (int s = 0; s < NS; s++)
      if (io_src_valid[s] && io_src_ready[s]) begin gnt_cyc.push_back(cyc); gnt_src.push_back(s); end
    if (int'(io_fifo_count) > max_cnt) max_cnt = int'(io_fifo_count);
    if (io_timeout && tmo_rise < 0) tmo_rise = cyc;
  end

  task automatic drive_src();
    for (int i = 0; i < NS; i++) begin
      io_src_valid[i] = (src_h[i] < src_n[i]);
      io_src_type[i*TW +: TW] = (src_h[i] < src_n[i]) ? src_evt[i][src_h[i]] : '0;
    end
  endtask

  task automatic add_evt(input int s, input logic [TW-1:0] t);
    src_evt[s][src_n[s]] = t;
    src_n[s]++;
    drive_src();
  endtask

  // Advance one cycle; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    for (int i = 0; i < NS; i++) if (gnt_last[i]) src_h[i]++;
    if (auto_proc && processed != recv) processed = recv;
    if (auto_ack && strobe_last) recv = recv + 32'd1;
    drive_src();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic clear_logs();
    post_cyc.delete(); post_typ.delete();
    gnt_cyc.delete();  gnt_src.delete();
    max_cnt = 0; tmo_rise = -1;
  endtask

  task automatic at_neg();
    @(negedge clock);
    #1;
  endtask

  int g0, c1;

  initial begin
    reset = 1'b1; io_has_event_rd = 1'b0;
    recv = '0; processed = '0;
    io_src_valid = '0; io_src_type = '0;
    strobe_last = 1'b0; gnt_last = '0;
    auto_ack = 1'b1; auto_proc = 1'b1;
    for (int i = 0; i < NS; i++) begin src_n[i] = 0; src_h[i] = 0; end
    clear_logs();
    drive_src();

    // Reset values
    ticks(3);
    at_neg();
    chk("rst_count", io_fifo_count, 0);
    chk("rst_wr", io_has_event_wr, 0);
    chk("rst_type", io_event_type_wr, 0);
    chk("rst_ready", io_src_ready, 0);
    chk("rst_timeout", io_timeout, 0);
    reset = 1'b0;

    // Single event, idle CSR: strobe two cycles after the grant
    tick(); clear_logs();
    add_evt(0, 32'h11); g0 = cyc;
    ticks(10);
    chk("t1_ngnt", gnt_cyc.size(), 1);
    chk("t1_gnt_cyc", gnt_cyc[0], g0);
    chk("t1_npost", post_cyc.size(), 1);
    chk("t1_post_cyc", post_cyc[0], g0 + 2);
    chk("t1_post_typ", post_typ[0], 32'h11);

    // All sources at once from pointer 0: in-order grants, posts every 3 cycles
    do_reset(); clear_logs();
    for (int i = 0; i < NS; i++) add_evt(i, 32'hA0 + i);
    g0 = cyc;
    ticks(20);
    chk("t2_ngnt", gnt_cyc.size(), 4);
    chk("t2_npost", post_cyc.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_gnt_src", gnt_src[i], i);
      chk("t2_gnt_cyc", gnt_cyc[i], g0 + i);
      chk("t2_post_typ", post_typ[i], 32'hA0 + i);
      chk("t2_post_cyc", post_cyc[i], g0 + 2 + 3 * i);
    end

    // FIFO full: processed held behind, five events into depth four
    do_reset(); clear_logs();
    auto_proc = 1'b0;
    recv = recv + 32'd1;
    for (int i = 0; i < NS; i++) add_evt(i, 32'hB0 + i);
    add_evt(1, 32'hB4);
    g0 = cyc;
    ticks(6);
    at_neg();
    chk("t3_count_full", io_fifo_count, 4);
    chk("t3_ready_full", io_src_ready, 0);
    chk("t3_ngnt", gnt_cyc.size(), 4);
    chk("t3_gnt3_cyc", gnt_cyc[3], g0 + 3);
    tick();
    processed = recv; auto_proc = 1'b1; c1 = cyc;
    ticks(25);
    chk("t3_max_cnt", max_cnt, 4);
    chk("t3_post0_cyc", post_cyc[0], c1 + 1);
    chk("t3_gnt4_cyc", gnt_cyc[4], c1 + 2);
    chk("t3_gnt4_src", gnt_src[4], 1);
    chk("t3_npost", post_cyc.size(), 5);
    for (int i = 0; i < 5; i++) chk("t3_post_typ", post_typ[i], 32'hB0 + i);

    // Counter wrap: recv 0xFFFFFFFF -> 0 still counts as acceptance
    do_reset(); clear_logs();
    recv = 32'hFFFF_FFFF; processed = 32'hFFFF_FFFF;
    add_evt(2, 32'hC1); add_evt(3, 32'hC2);
    g0 = cyc;
    ticks(12);
    chk("t4_npost", post_cyc.size(), 2);
    chk("t4_post0_typ", post_typ[0], 32'hC1);
    chk("t4_post1_typ", post_typ[1], 32'hC2);
    chk("t4_post0_cyc", post_cyc[0], g0 + 2);
    chk("t4_post1_cyc", post_cyc[1], g0 + 5);

    // Reset while waiting for acceptance with two events queued
    do_reset(); clear_logs();
    auto_ack = 1'b0;
    add_evt(0, 32'hD0); add_evt(1, 32'hD1); add_evt(2, 32'hD2);
    ticks(8);
    at_neg();
    chk("t5_count_wait", io_fifo_count, 2);
    chk("t5_npost_wait", post_cyc.size(), 1);
    do_reset();
    at_neg();
    chk("t5_count_rst", io_fifo_count, 0);
    chk("t5_wr_rst", io_has_event_wr, 0);
    chk("t5_type_rst", io_event_type_wr, 0);
    chk("t5_ready_rst", io_src_ready, 0);
    chk("t5_tmo_rst", io_timeout, 0);
    clear_logs();
    ticks(10);
    chk("t5_no_repost", post_cyc.size(), 0);

    // Ack never arrives: timeout (when built in) or indefinite WAIT
    do_reset(); clear_logs();
    add_evt(0, 32'hE0); add_evt(1, 32'hE1);
    g0 = cyc;
    ticks(30);
    chk("t6_post0_cyc", post_cyc[0], g0 + 2);
    if (TMO_EN) begin
      chk("t6_tmo_rise", tmo_rise, g0 + 19);
      chk("t6_npost", post_cyc.size(), 2);
      chk("t6_post1_cyc", post_cyc[1], g0 + 20);
      chk("t6_post1_typ", post_typ[1], 32'hE1);
      chk("t6_tmo_sticky", io_timeout, 1);
    end else begin
      chk("t6_npost", post_cyc.size(), 1);
      chk("t6_tmo_zero", io_timeout, 0);
      chk("t6_count", io_fifo_count, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/event_dispatcher.md
# event_dispatcher

Collects event requests from several hardware sources, buffers them in a small FIFO, and posts them one at a time into the core CSR unit's event interface. It drives the CSR unit's event-write strobe only when the core has fully drained the previous event. It sits between peripheral event sources and the CSR unit, which owns the recv/processed counters and the event-type register.

## Interface
- NUM_SRC, 4: number of event sources (2..8)
- FIFO_DEPTH, 4: pending-event FIFO entries (power of two, ≥2)
- TYPE_W, 32: event-type width; matches the CSR event-type register
- TIMEOUT_CYCLES, 1024: ack timeout; used only with EVENT_DISPATCHER_TIMEOUT_EN

- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- io_src_valid  in  NUM_SRC  per-source request
- io_src_ready  out  NUM_SRC  per-source grant; transfer when valid&ready
- io_src_type  in  NUM_SRC*TYPE_W  source i's type in bits [i*TYPE_W +: TYPE_W]
- io_has_event_rd  in  1  CSR unit: event pending, not yet taken by core
- io_event_recv_cnt  in  32  CSR unit: events received
- io_event_processed_cnt  in  32  CSR unit: events completed by core
- io_has_event_wr  out  1  one-cycle strobe posting io_event_type_wr
- io_event_type_wr  out  TYPE_W  type of the posted event
- io_fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
- io_timeout  out  1  sticky ack-timeout flag (0 when macro absent)

## Operation
- Intake: round-robin arbiter over sources with valid asserted. At most one grant per cycle, only when FIFO not full. The grant pointer advances to one past the granted source; it is unchanged when nothing is granted.
- io_src_ready is combinational. It is one-hot on the arbiter winner when the FIFO is not full and zero when it is full.
- FSM states:
  - IDLE: move to POST when FIFO non-empty AND io_has_event_rd==0 AND io_event_recv_cnt==io_event_processed_cnt.
  - POST: one cycle. io_has_event_wr=1 and io_event_type_wr=FIFO head. Pop the head and snapshot io_event_recv_cnt. Next state is WAIT.
  - WAIT: return to IDLE when io_event_recv_cnt != snapshot, i.e. the CSR unit accepted the event.
- Simultaneous push and pop: allowed in the same cycle. Occupancy is unchanged. A push into an empty FIFO is not visible to IDLE until the next cycle.
- Counter compare uses full 32-bit equality, so wrap-around of the CSR counters is transparent.
- Reset mid-operation: FIFO emptied, FSM to IDLE, pointer to source 0. Any event in WAIT is abandoned and not re-posted.
- Reset values: io_has_event_wr=0, io_event_type_wr=0, io_src_ready=0, io_fifo_count=0, io_timeout=0.

## Timing
- Intake: a request granted in cycle N is at the FIFO head in cycle N+1.
- Latency from an empty FIFO with the CSR unit idle: grant in N, IDLE qualifies in N+1, io_has_event_wr high in N+2.
- io_event_type_wr is valid only while io_has_event_wr=1. It holds its last posted value otherwise.
- Minimum post spacing is 3 cycles (POST, WAIT, IDLE), plus the time the core takes to process.
- Full FIFO: io_src_ready=0 to all sources. No drop, no overwrite.

## Configuration
- EVENT_DISPATCHER_TIMEOUT_EN defined:
  - A 32-bit counter runs in WAIT and clears on leaving WAIT.
  - When it reaches TIMEOUT_CYCLES, the FSM returns to IDLE and io_timeout is set. io_timeout clears only on reset.
  - The event is not re-posted.
- Undefined: no counter. WAIT holds indefinitely and io_timeout is tied to 0.

## Structure
- Shared package event_dispatcher_pkg holds:
  - the FSM state enum (IDLE, POST, WAIT)
  - the default parameter constants
  - a localparam for the counter width (32)
- Sub-module event_fifo: synchronous FIFO with push, pop, full, empty and count. Parameterised on width and depth, single clock, synchronous reset.
- Arbiter and FSM live in the top module.

## Test plan
- Single source 0 pushes type 0x11 with the CSR unit idle (rd=0, recv=processed=0): io_has_event_wr pulses once with type 0x11, 2 cycles after the grant. The bench increments recv, and the FSM returns to IDLE.
- All 4 sources are valid with types 0xA0..0xA3 and the pointer at 0: grants go 0,1,2,3 on consecutive cycles. Posts occur in order A0..A3, each only after the bench sets processed=recv.
- FIFO full: hold the bench's processed count behind and push 5 events into depth 4. The fifth source sees ready=0 until one pop, and io_fifo_count peaks at 4.
- Counter wrap: preload recv=processed=0xFFFFFFFF and post an event. The bench increments recv to 0x00000000, WAIT exits, and the next event posts after processed catches up.
- Reset asserted during WAIT with 2 events queued: the cycle after reset, count=0, no strobe, all outputs at reset values.
- With EVENT_DISPATCHER_TIMEOUT_EN and TIMEOUT_CYCLES=16: never increment recv. io_timeout rises 16 cycles into WAIT, the FSM returns to IDLE, and the next queued event posts normally.
